fp_to_int: RTL

- Multi-cycle converter from an IEEE 754 single-precision operand to a 32-bit signed or unsigned integer.
- Decodes the format that the FP add/sub unit produces, so results can be handed to integer logic.
- Uses an iterative shift datapath under a start/done handshake, with saturation and exception/inexact flags.
- Sits beside the FP arithmetic units in ALU_master.

---
 rtl/fp_pkg.sv | 31 +++
 rtl/fp_round_sat.sv | 51 +++++
 rtl/fp_to_int.sv | 124 ++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared constants, field positions and state encoding for fp_to_int
package fp_pkg;
    localparam int EXP_BIAS = 127;
    localparam logic [7:0] EXP_INF = 8'hFF;

    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int FRAC_MSB = 22;

    localparam logic [31:0] INT32_MAX    = 32'h7FFF_FFFF;
    localparam logic [31:0] INT32_MIN    = 32'h8000_0000;
    localparam logic [31:0] UINT32_MAX   = 32'hFFFF_FFFF;
    localparam logic [31:0] FP_INT32_MIN = 32'hCF00_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_ROUND
    } state_t;

    // Operand classes resolved at capture time; the shift datapath is bypassed for them.
    typedef struct packed {
        logic nan;
        logic inf;
        logic tiny;
        logic tiny_nz;
        logic ovf;
        logic minint;
    } special_t;
endpackage

// File: rtl/fp_round_sat.sv
// rtl/fp_round_sat.sv - combinational round, negate and saturate stage of fp_to_int
// Optional: ROUND_NEAREST_EN selects round-to-nearest-even instead of truncation.
module fp_round_sat
    import fp_pkg::*;
(
    input  logic [55:0] i_w,
    input  logic        i_s,
    input  logic        i_is_signed,
    input  special_t    i_sp,
    output logic [31:0] o_val,
    output logic        o_exc,
    output logic        o_inexact
);
    logic [31:0] w_mag;
    logic        w_inx;

    assign w_inx = |i_w[23:0];
`ifdef ROUND_NEAREST_EN
    // Increment only reaches here for e<23, so it never carries past bit 31.
    assign w_mag = i_w[55:24] + {31'b0, i_w[23] & ((|i_w[22:0]) | i_w[24])};
`else
    assign w_mag = i_w[55:24];
`endif

    always_comb begin
        o_val     = '0;
        o_exc     = 1'b0;
        o_inexact = 1'b0;
        if (i_sp.nan) begin
            o_val = i_is_signed ? INT32_MAX : UINT32_MAX;
            o_exc = 1'b1;
        end else if (i_sp.inf || (i_sp.ovf && !i_sp.minint)) begin
            if (i_is_signed) o_val = i_s ? INT32_MIN : INT32_MAX;
            else             o_val = i_s ? 32'd0 : UINT32_MAX;
            o_exc = 1'b1;
        end else if (i_sp.minint) begin
            o_val = INT32_MIN;
        end else if (i_sp.tiny) begin
            o_inexact = i_sp.tiny_nz;
        end else begin
            o_inexact = w_inx;
            if (i_is_signed) begin
                o_val = i_s ? (~w_mag + 32'd1) : w_mag;
            end else if (i_s && (w_mag != 32'd0)) begin
                o_exc = 1'b1;
            end else begin
                o_val = w_mag;
            end
        end
    end
endmodule

// File: rtl/fp_to_int.sv
// rtl/fp_to_int.sv - iterative IEEE 754 single to int32/uint32 converter with start/done handshake
// Optional: ROUND_NEAREST_EN (handled inside fp_round_sat).
module fp_to_int
    import fp_pkg::*;
#(
    parameter int INT_W = 32
) (
    input  logic             control,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      A,
    input  logic             is_signed,
    output logic [INT_W-1:0] out,
    output logic             busy,
    output logic             done,
    output logic             exception,
    output logic             inexact
);
    state_t      r_state, w_next;
    logic [55:0] r_w, w_wload;
    logic [4:0]  r_k, w_kload;
    logic        r_s, r_is_signed;
    special_t    r_sp, w_sp;
    logic [8:0]  w_e;
    logic [INT_W-1:0] r_out;
    logic        r_busy, r_done, r_exc, r_inx;
    logic [31:0] w_val;
    logic        w_exc, w_inx;

    assign w_e = {1'b0, A[EXP_MSB:EXP_LSB]} - 9'(EXP_BIAS);

    always_comb begin
        w_sp    = '0;
        w_wload = '0;
        w_kload = '0;
        if (A[EXP_MSB:EXP_LSB] == EXP_INF) begin
            w_sp.nan = |A[FRAC_MSB:0];
            w_sp.inf = ~|A[FRAC_MSB:0];
        end else if (A[EXP_MSB:EXP_LSB] == 8'd0 || $signed(w_e) <= -9'sd2) begin
            w_sp.tiny    = 1'b1;
            w_sp.tiny_nz = |A[EXP_MSB:0];
        end else if ($signed(w_e) == -9'sd1) begin
            w_wload = {32'b0, 1'b1, A[FRAC_MSB:0]};
        end else if ((is_signed && $signed(w_e) >= 9'sd31) ||
                     (!is_signed && $signed(w_e) >= 9'sd32)) begin
            w_sp.ovf    = 1'b1;
            w_sp.minint = is_signed && (A == FP_INT32_MIN);
        end else begin
            // Leading one sits at bit 24 so that e left shifts align it to 2^e.
            w_wload = {31'b0, 1'b1, A[FRAC_MSB:0], 1'b0};
            w_kload = w_e[4:0];
        end
    end

    always_ff @(posedge control or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_next = ST_SHIFT;
            ST_SHIFT: if (r_k == 5'd0) w_next = ST_ROUND;
            ST_ROUND: w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge control or posedge reset) begin
        if (reset) begin
            r_w         <= '0;
            r_k         <= '0;
            r_s         <= 1'b0;
            r_is_signed <= 1'b0;
            r_sp        <= '0;
            r_out       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_exc       <= 1'b0;
            r_inx       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: if (start) begin
                    r_w         <= w_wload;
                    r_k         <= w_kload;
                    r_s         <= A[SIGN_BIT];
                    r_is_signed <= is_signed;
                    r_sp        <= w_sp;
                    r_busy      <= 1'b1;
                end
                ST_SHIFT: if (r_k != 5'd0) begin
                    r_w <= r_w << 1;
                    r_k <= r_k - 5'd1;
                end
                ST_ROUND: begin
                    r_out  <= w_val;
                    r_exc  <= w_exc;
                    r_inx  <= w_inx;
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    fp_round_sat u_round_sat (
        .i_w         (r_w),
        .i_s         (r_s),
        .i_is_signed (r_is_signed),
        .i_sp        (r_sp),
        .o_val       (w_val),
        .o_exc       (w_exc),
        .o_inexact   (w_inx)
    );

    assign out       = r_out;
    assign busy      = r_busy;
    assign done      = r_done;
    assign exception = r_exc;
    assign inexact   = r_inx;
endmodule
